// File: rtl/instr_prefetch_buffer_if.sv
// Fetch-side bundle for the instruction prefetch buffer: core fetch handshake plus
// the req/gnt/rvalid instruction port toward the RAM. master = prefetch buffer.
interface instr_prefetch_buffer_if;
  logic        req;
  logic        branch;
  logic [31:0] branch_addr;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic [31:0] addr;
  logic        err;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    input  req, branch, branch_addr, ready, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output valid, rdata, addr, err, busy, mem_req, mem_addr
  );

  modport slave (
    output req, branch, branch_addr, ready, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  valid, rdata, addr, err, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch stage: issues sequential word fetches ahead of the core,
// buffers returned words with their error flag in a small FIFO, redirects on branch.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0
) (
  input logic                     clk,
  input logic                     rst,
  instr_prefetch_buffer_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 2;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, STALE} state_t;

  state_t        state_reg;
  logic          mem_req_reg;
  logic [31:0]   mem_addr_reg;
  logic [31:0]   fetch_addr_reg;
  logic [31:0]   head_addr_reg, head_addr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [32:0]   fifo_reg [DEPTH];

  logic          granted;
  logic          rvalid_eff;
  logic          drop;
  logic          push;
  logic          pop;
  logic          space;
  logic          go;
  logic [31:0]   target;
  logic [32:0]   head;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.branch_addr[1:0];

  always_comb begin
    granted    = mem_req_reg & bus.mem_gnt;
    rvalid_eff = bus.mem_rvalid & (outstanding_reg != '0);
    drop       = discard_reg != '0;
    target     = {bus.branch_addr[31:2], 2'b00};
    pop        = (count_reg != '0) & bus.ready & ~bus.branch;
    push       = rvalid_eff & ~drop & ~bus.branch;

    outstanding_next = outstanding_reg + CW'(granted) - CW'(rvalid_eff);
    head_addr_next   = pop ? head_addr_reg + 32'd4 : head_addr_reg;

    if (bus.branch) begin
      count_next     = '0;
      rd_ptr_next    = '0;
      wr_ptr_next    = '0;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_next   = outstanding_next;
      head_addr_next = target;
    end else begin
      count_next   = count_reg + CW'(push) - CW'(pop);
      rd_ptr_next  = rd_ptr_reg + PW'(pop);
      wr_ptr_next  = wr_ptr_reg + PW'(push);
      discard_next = discard_reg - CW'(rvalid_eff & drop)
                   + CW'(granted & (state_reg == STALE));
    end

    // Judged on next-cycle occupancy so a request is only raised when its word has a slot.
    space = (({1'b0, count_next} + {1'b0, outstanding_next}) < SW'(DEPTH))
          && (outstanding_next < CW'(MAX_OUTSTANDING));
    go    = bus.req & space;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= BOOT_ADDR;
      fetch_addr_reg <= BOOT_ADDR;
    end else if (bus.branch) begin
      fetch_addr_reg <= target;
      if (mem_req_reg && !bus.mem_gnt) begin
        // A pending request cannot be withdrawn; finish it at the old address first.
        state_reg <= STALE;
      end else begin
        mem_addr_reg <= target;
        mem_req_reg  <= go;
        state_reg    <= go ? FETCH : IDLE;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (go) begin
            state_reg   <= FETCH;
            mem_req_reg <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.mem_gnt) begin
            fetch_addr_reg <= fetch_addr_reg + 32'd4;
            mem_addr_reg   <= fetch_addr_reg + 32'd4;
            mem_req_reg    <= go;
            state_reg      <= go ? FETCH : IDLE;
          end
        end
        STALE: begin
          if (bus.mem_gnt) begin
            mem_addr_reg <= fetch_addr_reg;
            mem_req_reg  <= go;
            state_reg    <= go ? FETCH : IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      head_addr_reg   <= BOOT_ADDR;
    end else begin
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      head_addr_reg   <= head_addr_next;
    end
  end

  // Register-based entries: the head must be readable the cycle after the push.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          fifo_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          fifo_reg[gi] <= {bus.mem_err, bus.mem_rdata};
        end
      end
    end
  endgenerate

  assign head         = fifo_reg[rd_ptr_reg];
  assign bus.valid    = count_reg != '0;
  assign bus.rdata    = head[31:0];
  assign bus.err      = head[32];
  assign bus.addr     = head_addr_reg;
  assign bus.mem_req  = mem_req_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.busy     = mem_req_reg | (outstanding_reg != '0);
endmodule
